// File: rtl/alu_issue_ctrl.sv
// Operand-fetch / issue / writeback stage in front of the 8-bit alu.
// Owns an 8x8 register file. It takes one register-to-register
// instruction at a time, drives the ALU operands, waits out the ALU
// latency, and writes the registered ALU result back to rd.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 2,   // edges from the ALU sampling A/B/CTR to O0 valid; must be >= 2
    parameter int NREG    = 8
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_ctr,
    input  logic [2:0] in_rd,
    input  logic [2:0] in_ra,
    input  logic [2:0] in_rb,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_ctr,
    input  logic [7:0] alu_o,
    input  logic       ld_en,
    input  logic [2:0] ld_addr,
    input  logic [7:0] ld_data,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(ALU_LAT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     rd_q;
    logic [3:0]     ctr_q;
    logic [7:0]     regs [NREG];
    logic           accept;
    logic           ld_ok;
    logic           wb_en;
    logic [7:0]     wb_data;

    // State register; the latency counter rides along with it.
    always_ff @(posedge ck) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= '0;
            else if (state == ISSUE || state == WAIT)
                cnt <= cnt + CW'(1);
        end
    end

    // Next-state: WAIT leaves once ALU_LAT edges have passed since the accept.
    always_comb begin
        // NOTE: default first so no path through this block leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:  if (in_valid) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (cnt == CW'(ALU_LAT - 1)) state_nxt = WB;
            WB:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        accept   = (state == IDLE) && in_valid;
        ld_ok    = (state == IDLE) && ld_en;
        wb_en    = (state == WB);
        // Codes 0010..0111 are reserved and always write zero.
        wb_data  = (ctr_q >= 4'd2 && ctr_q <= 4'd7) ? 8'h00 : alu_o;
    end

    // Datapath: operand issue, instruction latch, done pulse and register file.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_ctr <= '0;
            rd_q    <= '0;
            ctr_q   <= '0;
            done    <= 1'b0;
            // NOTE: the register file is flop-based and must read as zero after reset, so it is cleared here.
            for (int i = 0; i < NREG; i++)
                regs[i] <= 8'h00;
        end else begin
            done <= wb_en;
            if (accept) begin
                // NOTE: operands come from the pre-edge array, so a same-edge load is not seen (read-before-write).
                alu_a   <= regs[in_ra];
                alu_b   <= regs[in_rb];
                alu_ctr <= in_ctr;
                rd_q    <= in_rd;
                ctr_q   <= in_ctr;
            end
            // Loads happen only in IDLE and writeback only in WB, so the two never collide.
            if (ld_ok)
                regs[ld_addr] <= ld_data;
            if (wb_en)
                regs[rd_q] <= wb_data;
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. A behavioural two-stage ALU is
// wired in place of the real alu. Expected register contents come from
// a reference register array that applies each instruction's rule.
module tb_alu_issue_ctrl;

    logic       ck = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_ctr;
    logic [2:0] in_rd, in_ra, in_rb;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_ctr;
    logic [7:0] alu_o;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       busy, done;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_regs [8];

    always #10 ck = ~ck;

    alu_issue_ctrl #(.ALU_LAT(2), .NREG(8)) dut (
        .ck(ck), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctr(in_ctr), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy), .done(done)
    );

    // ALU operation table. Reserved codes return junk so that a missing
    // zero-forcing in the DUT shows up.
    function automatic logic [7:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            4'b1011: return ~a;
            4'b1100: return a << 1;
            4'b1101: return a >> 1;
            4'b1110: return 8'($signed(a) >>> 1);
            4'b1111: return 8'((a << 1) | (a >> 7));
            default: return a ^ b ^ 8'h5A;
        endcase
    endfunction

    // Value written back to rd for an instruction.
    function automatic logic [7:0] ref_result(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        if (c >= 4'd2 && c <= 4'd7) return 8'h00;
        return alu_fn(c, a, b);
    endfunction

    // Behavioural alu: inputs registered, then output registered.
    logic [7:0] a_q, b_q;
    logic [3:0] c_q;
    always @(posedge ck) begin
        a_q   <= alu_a;
        b_q   <= alu_b;
        c_q   <= alu_ctr;
        alu_o <= alu_fn(c_q, a_q, b_q);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge ck);
        #1;
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [7:0] val);
        dbg_addr = addr;
        #1;
        val = dbg_data;
    endtask

    task automatic check_all_regs(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            checks++;
            if (v !== ref_regs[i]) begin
                errors++;
                $display("FAIL %s r%0d got %02h want %02h", tag, i, v, ref_regs[i]);
            end
        end
    endtask

    task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        step;
        ld_en = 1'b0;
        ref_regs[addr] = data;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step; step;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
    endtask

    // Single instruction with full timing checks from E0 to E4.
    task automatic issue(input logic [3:0] c, input logic [2:0] d, input logic [2:0] a,
                         input logic [2:0] b, input string tag);
        logic [7:0] oa, ob, exp, v;
        oa = ref_regs[a]; ob = ref_regs[b];
        exp = ref_result(c, oa, ob);
        in_ctr = c; in_rd = d; in_ra = a; in_rb = b; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_pre got %b want 1", tag, in_ready); end
        step;                                   // E0
        in_valid = 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_ctr} !== {oa, ob, c}) begin
            errors++;
            $display("FAIL %s operands got %02h/%02h/%h want %02h/%02h/%h", tag, alu_a, alu_b, alu_ctr, oa, ob, c);
        end
        checks++;
        if ({busy, in_ready, done} !== 3'b100) begin
            errors++; $display("FAIL %s after_e0 busy/ready/done got %b want 100", tag, {busy, in_ready, done});
        end
        step; step;                             // E1, E2
        checks++;
        if ({busy, in_ready, done} !== 3'b100) begin
            errors++; $display("FAIL %s after_e2 busy/ready/done got %b want 100", tag, {busy, in_ready, done});
        end
        step;                                   // E3: writeback
        checks++;
        if ({busy, in_ready, done} !== 3'b011) begin
            errors++; $display("FAIL %s after_e3 busy/ready/done got %b want 011", tag, {busy, in_ready, done});
        end
        ref_regs[d] = exp;
        read_reg(d, v);
        checks++;
        if (v !== exp) begin errors++; $display("FAIL %s result r%0d got %02h want %02h", tag, d, v, exp); end
        step;                                   // E4
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", tag, done); end
    endtask

    task automatic test_reset;
        checks++;
        if ({in_ready, busy, done} !== 3'b100) begin
            errors++; $display("FAIL reset ready/busy/done got %b want 100", {in_ready, busy, done});
        end
        checks++;
        if ({alu_a, alu_b, alu_ctr} !== 20'h0) begin
            errors++; $display("FAIL reset alu_outputs got %05h want 00000", {alu_a, alu_b, alu_ctr});
        end
        check_all_regs("reset");
    endtask

    task automatic test_add;
        do_load(3'd1, 8'h3C);
        do_load(3'd2, 8'h0F);
        issue(4'b0000, 3'd3, 3'd1, 3'd2, "add");
        checks++;
        if (ref_regs[3] !== 8'h4B || dbg_data !== 8'h4B) begin
            errors++; $display("FAIL add_const r3 got %02h want 4b", dbg_data);
        end
    endtask

    task automatic test_sub_shift;
        do_load(3'd4, 8'h05);
        do_load(3'd5, 8'h0A);
        issue(4'b0001, 3'd6, 3'd4, 3'd5, "sub_wrap");
        do_load(3'd7, 8'h81);
        issue(4'b1110, 3'd0, 3'd7, 3'd7, "asr");
        issue(4'b1111, 3'd1, 3'd7, 3'd7, "rol");
        check_all_regs("sub_shift");
    endtask

    task automatic test_reserved;
        do_load(3'd1, 8'hFF);
        do_load(3'd2, 8'h99);
        issue(4'b0011, 3'd2, 3'd1, 3'd1, "reserved");
        for (int c = 2; c <= 7; c++) begin
            do_load(3'd5, 8'hA7);
            issue(4'(c), 3'd5, 3'd1, 3'd7, "reserved_sweep");
        end
    endtask

    task automatic test_random;
        logic [3:0] c;
        for (int n = 0; n < 25; n++) begin
            do_load(3'($urandom_range(0, 7)), 8'($urandom));
            do_load(3'($urandom_range(0, 7)), 8'($urandom));
            c = 4'($urandom);
            issue(c, 3'($urandom), 3'($urandom), 3'($urandom), "random");
        end
        check_all_regs("random");
    endtask

    typedef struct {
        logic [3:0] c;
        logic [2:0] d, a, b;
    } ins_t;

    task automatic test_back_to_back;
        ins_t prog[3];
        int idx = 0;
        int acc_cyc[3];
        int done_cnt = 0;
        prog[0] = '{c: 4'b0000, d: 3'd1, a: 3'd1, b: 3'd2};
        prog[1] = '{c: 4'b0000, d: 3'd1, a: 3'd1, b: 3'd2};
        prog[2] = '{c: 4'b0001, d: 3'd4, a: 3'd1, b: 3'd2};
        do_load(3'd1, 8'h11);
        do_load(3'd2, 8'h22);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (idx < 3) begin
                in_valid = 1'b1;
                in_ctr = prog[idx].c; in_rd = prog[idx].d; in_ra = prog[idx].a; in_rb = prog[idx].b;
            end else begin
                in_valid = 1'b0;
            end
            checks++;
            if (in_ready !== ((cyc % 4) == 0)) begin
                errors++; $display("FAIL b2b ready cyc%0d got %b want %b", cyc, in_ready, (cyc % 4) == 0);
            end
            if (in_ready && in_valid && idx < 3) begin
                ref_regs[prog[idx].d] = ref_result(prog[idx].c, ref_regs[prog[idx].a], ref_regs[prog[idx].b]);
                acc_cyc[idx] = cyc;
                idx++;
            end
            step;
            if (done) done_cnt++;
            checks++;
            if (done !== ((cyc % 4) == 3)) begin
                errors++; $display("FAIL b2b done cyc%0d got %b want %b", cyc, done, (cyc % 4) == 3);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 3 || acc_cyc[0] != 0 || acc_cyc[1] != 4 || acc_cyc[2] != 8) begin
            errors++; $display("FAIL b2b accepts got %0d at %0d,%0d,%0d want 3 at 0,4,8", idx, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        checks++;
        if (done_cnt != 3) begin errors++; $display("FAIL b2b done_count got %0d want 3", done_cnt); end
        check_all_regs("b2b");
        checks++;
        if (ref_regs[1] !== 8'h55 || ref_regs[4] !== 8'h33) begin
            errors++; $display("FAIL b2b chain ref r1 %02h r4 %02h want 55 33", ref_regs[1], ref_regs[4]);
        end
    endtask

    task automatic test_load;
        logic [7:0] v;
        // Load while busy is dropped.
        do_load(3'd5, 8'h42);
        in_ctr = 4'b0000; in_rd = 3'd3; in_ra = 3'd5; in_rb = 3'd5; in_valid = 1'b1;
        step;                                   // E0
        in_valid = 1'b0;
        ref_regs[3] = ref_result(4'b0000, ref_regs[5], ref_regs[5]);
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = 8'h77;
        step;                                   // E1
        step;                                   // E2
        ld_addr = 3'd6;
        step;                                   // E3
        ld_en = 1'b0;
        step;
        check_all_regs("load_busy");
        // Load and accept at the same edge: operands use the old r1.
        do_load(3'd1, 8'h10);
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'hE0;
        in_ctr = 4'b0000; in_rd = 3'd3; in_ra = 3'd1; in_rb = 3'd1; in_valid = 1'b1;
        step;                                   // E0
        ld_en = 1'b0; in_valid = 1'b0;
        checks++;
        if (alu_a !== 8'h10 || alu_b !== 8'h10) begin
            errors++; $display("FAIL load_same_edge operands got %02h/%02h want 10/10", alu_a, alu_b);
        end
        ref_regs[1] = 8'hE0;
        ref_regs[3] = 8'h20;
        step; step; step; step;
        read_reg(3'd1, v);
        checks++;
        if (v !== 8'hE0) begin errors++; $display("FAIL load_same_edge r1 got %02h want e0", v); end
        check_all_regs("load_same_edge");
    endtask

    task automatic test_reset_mid;
        do_reset;
        do_load(3'd1, 8'h3C);
        do_load(3'd2, 8'h0F);
        in_ctr = 4'b0000; in_rd = 3'd3; in_ra = 3'd1; in_rb = 3'd2; in_valid = 1'b1;
        step;                                   // E0
        in_valid = 1'b0;
        step;                                   // E1
        rst_n = 1'b0;
        step;                                   // E2 with reset
        rst_n = 1'b1;
        checks++;
        if ({in_ready, busy, done} !== 3'b100) begin
            errors++; $display("FAIL reset_mid ready/busy/done got %b want 100", {in_ready, busy, done});
        end
        checks++;
        if ({alu_a, alu_b, alu_ctr} !== 20'h0) begin
            errors++; $display("FAIL reset_mid alu_outputs got %05h want 00000", {alu_a, alu_b, alu_ctr});
        end
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step;
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL reset_mid done cyc%0d got %b want 0", k, done); end
        end
        check_all_regs("reset_mid");
    endtask

    initial begin
        in_valid = 1'b0; in_ctr = '0; in_rd = '0; in_ra = '0; in_rb = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        do_reset;
        test_reset;
        test_add;
        test_sub_shift;
        test_reserved;
        test_random;
        test_back_to_back;
        test_load;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
